axis_fifo_sync_pkt: RTL
=======================

# axis_fifo_sync_pkt

Synchronous single-clock AXI4-Stream FIFO with TLAST pass-through, programmable almost-full/almost-empty flags, an overflow drop counter, and an optional store-and-forward packet mode. It is the parametrised successor of the team's plain synchronous stream FIFO. It sits between ADC/DSP stream producers and DMA/packetiser consumers that need frame boundaries preserved and back-pressure visibility.

## Interface
- AXIS_TDATA_WIDTH, 32: data width in bits.
- ADDR_WIDTH, 9: RAM address bits; DEPTH = 2^ADDR_WIDTH words total capacity.
- ALWAYS_READY, "FALSE": if "TRUE", s_axis_tready is tied to 1 and words arriving while full are dropped.
- ALMOST_FULL, 496: almost_full asserted when count >= ALMOST_FULL.
- ALMOST_EMPTY, 16: almost_empty asserted when count <= ALMOST_EMPTY.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, synchronous, active-low.
- s_axis_tdata  in  AXIS_TDATA_WIDTH  input data.
- s_axis_tlast  in  1  input end-of-packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  AXIS_TDATA_WIDTH  output data.
- m_axis_tlast  out  1  output end-of-packet.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- count  out  ADDR_WIDTH+1  words held (RAM plus output register), 0..DEPTH.
- pkt_count  out  ADDR_WIDTH+1  complete packets held (TLAST words accepted minus TLAST words emitted).
- almost_full  out  1  count >= ALMOST_FULL.
- almost_empty  out  1  count <= ALMOST_EMPTY.
- drop_count  out  16  words discarded on overflow; wraps modulo 2^16.

## Operation
- Storage: DEPTH x (AXIS_TDATA_WIDTH+1) RAM holding {tlast, tdata}. Write and read pointers are ADDR_WIDTH+1 bits, and the MSB distinguishes full from empty. The RAM read feeds a one-entry output register.
- Write accepted when s_axis_tvalid & (count < DEPTH). In BLOCKING mode, s_axis_tready = (count < DEPTH) exactly each cycle; it is registered from next-state occupancy.
- ALWAYS_READY="TRUE": s_axis_tready=1. A valid word arriving while count == DEPTH is discarded, drop_count increments, and pointers and pkt_count are unchanged.
- Read: an output word is consumed on m_axis_tvalid & m_axis_tready. The output register reloads from RAM in the same edge if data is available, giving one word per cycle sustained.
- count, pkt_count, almost_full and almost_empty are registered and updated on the edge after the causing handshake.
- Simultaneous write and read: count unchanged. If both words carry tlast, pkt_count is unchanged.

## Timing
- Reset values: s_axis_tready=0 during reset and 1 from the first cycle after release (BLOCKING mode). m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, count=0, pkt_count=0, almost_full=0, almost_empty=1, drop_count=0.
- Reset mid-operation discards all contents within one edge. drop_count is cleared.
- Latency, empty FIFO: a word accepted at edge k presents m_axis_tvalid=1 after edge k+2.
- Throughput: 1 word/cycle in and out simultaneously, at any occupancy including 0 < count < DEPTH.
- Full: while count == DEPTH, s_axis_tready=0 even if a read occurs that cycle. tready rises after the read edge.
- Wrap-around: pointers wrap modulo 2·DEPTH with no bubble.
- m_axis_tvalid, once asserted, holds with stable tdata/tlast until the handshake.

## Configuration
- AXIS_FIFO_SYNC_PKT_PACKET_MODE_EN defined: store-and-forward. The first word of a packet may load the output register only when pkt_count > 0. Once started, a packet streams to its tlast word.
  - Anti-deadlock release: if count == DEPTH and pkt_count == 0, output is released (cut-through) until the next tlast is emitted.
  - First word of a packet is valid no earlier than edge k+2, where k is the edge its tlast word was accepted.
- Undefined: cut-through. Output is independent of pkt_count, and pkt_count is still reported.

## Test plan
(ADDR_WIDTH=4, DEPTH=16, ALMOST_FULL=12, ALMOST_EMPTY=2.)
- Write 1 word 0xA5 into empty FIFO at edge k, m_axis_tready=1 -> m_axis_tvalid after edge k+2, tdata=0xA5; count 1 then 0.
- Write 20 words with m_axis_tready=0 -> 16 accepted, s_axis_tready=0 while count=16, almost_full=1 from count 12; read all -> data 0..15 in order, almost_empty=1 at count <= 2.
- Continuous write+read for 100 cycles with tready toggled pseudo-randomly -> no loss or duplication across pointer wrap; tlast preserved per word.
- ALWAYS_READY="TRUE": 18 words into full-stalled FIFO -> drop_count=2, words 16 and 17 absent from output.
- PACKET_MODE_EN: 5-word packet, tlast held off for 10 cycles -> m_axis_tvalid stays 0 until 2 edges after tlast accepted; pkt_count 0 then 1 then 0.
- PACKET_MODE_EN: 20-word packet -> anti-deadlock release at count=16, all 20 words emitted in order; assert aresetn=0 mid-stream -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/axis_fifo_sync_pkt.sv
// rtl/axis_fifo_sync_pkt.sv - single-clock AXI4-Stream FIFO with tlast, level flags and drop counter; store-and-forward when AXIS_FIFO_SYNC_PKT_PACKET_MODE_EN is defined
module axis_fifo_sync_pkt #(
    parameter int    AXIS_TDATA_WIDTH = 32,
    parameter int    ADDR_WIDTH       = 9,
    parameter string ALWAYS_READY     = "FALSE",
    parameter int    ALMOST_FULL      = 496,
    parameter int    ALMOST_EMPTY     = 16
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                        s_axis_tlast,
    input  logic                        s_axis_tvalid,
    output logic                        s_axis_tready,
    output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                        m_axis_tlast,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic [ADDR_WIDTH:0]         count,
    output logic [ADDR_WIDTH:0]         pkt_count,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [15:0]                 drop_count
);
    localparam int            DEPTH           = 1 << ADDR_WIDTH;
    localparam int            CW              = ADDR_WIDTH + 1;
    localparam bit            ALWAYS_READY_EN = (ALWAYS_READY == "TRUE");
    localparam logic [CW-1:0] DEPTH_C         = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C            = CW'(ALMOST_FULL);
    localparam logic [CW-1:0] AE_C            = CW'(ALMOST_EMPTY);
    localparam logic [CW-1:0] ONE             = CW'(1);

    // {tlast, tdata} storage
    logic [AXIS_TDATA_WIDTH:0] mem [DEPTH];

    // wr_ptr_vis lags wr_ptr by one edge so a written word reaches the
    // output register two edges after acceptance
    logic [CW-1:0]             wr_ptr, wr_ptr_vis, rd_ptr;
    logic [CW-1:0]             count_q, count_next;
    logic [CW-1:0]             pkt_q, pkt_next;
    logic                      tready_q;
    logic                      out_valid, out_last;
    logic [AXIS_TDATA_WIDTH-1:0] out_data;
    logic                      af_q, ae_q;
    logic [15:0]               drop_q;

    logic                      not_full, wr_en, rd_en, drop, ram_avail, load, load_allow;
    logic [AXIS_TDATA_WIDTH:0] rd_word;

    assign not_full  = (count_q < DEPTH_C);
    assign wr_en     = s_axis_tvalid & (ALWAYS_READY_EN ? not_full : tready_q);
    assign drop      = ALWAYS_READY_EN & s_axis_tvalid & ~not_full;
    assign rd_en     = out_valid & m_axis_tready;
    assign ram_avail = (rd_ptr != wr_ptr_vis);
    assign rd_word   = mem[rd_ptr[ADDR_WIDTH-1:0]];
    assign load      = ram_avail & load_allow & (~out_valid | rd_en);

`ifdef AXIS_FIFO_SYNC_PKT_PACKET_MODE_EN
    // sof_q: next word to load starts a packet; ram_pkts_q: tlast words in RAM
    // (counted one edge late, matching wr_ptr_vis); release_q: anti-deadlock
    logic          sof_q, release_q, tlast_wr_d;
    logic [CW-1:0] ram_pkts_q, ram_pkts_next;
    logic          load_last;

    assign load_last  = load & rd_word[AXIS_TDATA_WIDTH];
    assign load_allow = ~sof_q | (ram_pkts_q != '0) | release_q;

    // Count of complete packets sitting in RAM awaiting the output register
    always_comb begin
        ram_pkts_next = ram_pkts_q;
        if (tlast_wr_d & ~load_last)
            ram_pkts_next = ram_pkts_q + ONE;
        else if (~tlast_wr_d & load_last)
            ram_pkts_next = ram_pkts_q - ONE;
    end

    // Packet boundary tracking and cut-through release when full of a partial packet
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sof_q      <= 1'b1;
            release_q  <= 1'b0;
            tlast_wr_d <= 1'b0;
            ram_pkts_q <= '0;
        end else begin
            tlast_wr_d <= wr_en & s_axis_tlast;
            ram_pkts_q <= ram_pkts_next;
            if (load)
                sof_q <= rd_word[AXIS_TDATA_WIDTH];
            if (rd_en & out_last)
                release_q <= 1'b0;
            else if ((count_q == DEPTH_C) && (pkt_q == '0))
                release_q <= 1'b1;
        end
    end
`else
    assign load_allow = 1'b1;
`endif

    // Next-state occupancy and packet count from this cycle's handshakes
    always_comb begin
        count_next = count_q;
        pkt_next   = pkt_q;
        if (wr_en & ~rd_en)
            count_next = count_q + ONE;
        else if (~wr_en & rd_en)
            count_next = count_q - ONE;
        if ((wr_en & s_axis_tlast) & ~(rd_en & out_last))
            pkt_next = pkt_q + ONE;
        else if (~(wr_en & s_axis_tlast) & (rd_en & out_last))
            pkt_next = pkt_q - ONE;
    end

    // RAM write port
    always_ff @(posedge aclk) begin
        if (wr_en)
            mem[wr_ptr[ADDR_WIDTH-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

    // Pointers, output register, status flags and drop counter
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            wr_ptr_vis <= '0;
            rd_ptr     <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            count_q    <= '0;
            pkt_q      <= '0;
            tready_q   <= 1'b0;
            af_q       <= 1'b0;
            ae_q       <= 1'b1;
            drop_q     <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ONE;
            wr_ptr_vis <= wr_ptr;
            if (load) begin
                rd_ptr    <= rd_ptr + ONE;
                out_valid <= 1'b1;
                out_last  <= rd_word[AXIS_TDATA_WIDTH];
                out_data  <= rd_word[AXIS_TDATA_WIDTH-1:0];
            end else if (rd_en) begin
                out_valid <= 1'b0;
            end
            count_q  <= count_next;
            pkt_q    <= pkt_next;
            tready_q <= (count_next < DEPTH_C);
            af_q     <= (count_next >= AF_C);
            ae_q     <= (count_next <= AE_C);
            if (drop)
                drop_q <= drop_q + 16'd1;
        end
    end

    assign s_axis_tready = ALWAYS_READY_EN ? 1'b1 : tready_q;
    assign m_axis_tvalid = out_valid;
    assign m_axis_tlast  = out_last;
    assign m_axis_tdata  = out_data;
    assign count         = count_q;
    assign pkt_count     = pkt_q;
    assign almost_full   = af_q;
    assign almost_empty  = ae_q;
    assign drop_count    = drop_q;

endmodule
